data_mem_ctrl: RTL
==================

// Module: data_mem_ctrl
// PURPOSE
// - Parametrised byte-lane data memory behind a valid/ready request/response interface.
// - Successor of the fixed 1K-word load/store memory; sits on the CPU load/store path.
// - Adds configurable depth, an optional output pipeline stage and response backpressure.
// - Every request (load or store) returns exactly one in-order response with an error code.
// PARAMETERS
// - DEPTH_WORDS  1024  number of 32-bit words; power of two; word index = i_req_addr[2+:$clog2(DEPTH_WORDS)]
// - OUT_REG      0     0|1: extra register stage between array read and response FIFO
// - RSP_DEPTH    (localparam) 3+OUT_REG entries in the response FIFO; equals max outstanding requests
// PORTS
// - i_clk          in   1   clock, all state on posedge
// - i_reset_n      in   1   asynchronous, active-low reset
// - i_req_valid    in   1   request present
// - o_req_ready    out  1   request accepted on posedge when valid&&ready
// - i_req_addr     in   32  byte address
// - i_req_we       in   1   1=store, 0=load
// - i_req_size     in   2   mem_size_t: 0=B, 1=H, 2=W, 3=invalid
// - i_req_signed   in   1   loads only: 1=sign-extend, 0=zero-extend
// - i_req_wdata    in   32  store data; B uses [7:0], H uses [15:0]
// - o_rsp_valid    out  1   response at FIFO head
// - i_rsp_ready    in   1   response popped on posedge when valid&&ready
// - o_rsp_rdata    out  32  extended load data; 0 for stores and errored requests
// - o_rsp_err      out  2   mem_err_t: 0=OK, 1=MISALIGNED, 2=BAD_SIZE, 3=OUT_OF_RANGE
// BEHAVIOUR
// - Reset: o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, outstanding=0, FIFO and pipe valids cleared;
//   o_req_ready=1 immediately. Array contents are not reset and survive reset.
// - o_req_ready = (outstanding < RSP_DEPTH); depends only on registered state, never on i_rsp_ready.
// - outstanding: +1 on accept, -1 on pop, unchanged when both occur on the same edge.
// - Storage: 4 byte lanes, little-endian (lane n = byte addr[1:0]==n), synchronous read.
// - Accept at edge k: store writes enabled lanes at edge k; load reads all lanes at edge k.
// - Response pushed at edge k+1+OUT_REG; o_rsp_valid earliest high after that edge.
// - FIFO is in order and first-word-fall-through on registered storage; holds the head while !i_rsp_ready.
// - With i_rsp_ready=1 held: one request per cycle sustained, o_req_ready stays 1.
// - Lane select: B -> addr[1:0]; H -> addr[1] picks {1,0} or {3,2}; W -> all lanes.
// - Alignment: H with addr[0]=1, or W with addr[1:0]!=0 -> err MISALIGNED, no array write, rdata=0.
// - i_req_size=3 -> err BAD_SIZE, no write, rdata=0. Misaligned is checked before bad size.
// - Extension: signed load replicates the MSB of the selected B/H field; unsigned zero-fills. W ignores i_req_signed.
// - Ordering: a load accepted after a store to the same word returns the new data (write at edge k, read at edge k+1 or later).
// - Address bits above the index field are ignored unless the bounds-check feature is compiled in.
// - Reset mid-operation: in-flight and queued responses are dropped; a store accepted on an earlier edge stays written.
// CONFIGURATION
// - DMEM_BOUNDS_CHECK_EN defined: any nonzero i_req_addr bit above the index field -> err OUT_OF_RANGE.
//   No write, rdata=0. Priority: MISALIGNED > BAD_SIZE > OUT_OF_RANGE.
// - Not defined: upper address bits alias silently; err code 3 is never produced.
// STRUCTURE
// - Package argon_mem_pkg holds:
//   - mem_size_t enum {SZ_B, SZ_H, SZ_W, SZ_BAD}
//   - mem_err_t enum {ERR_OK, ERR_MISALIGNED, ERR_BAD_SIZE, ERR_OUT_OF_RANGE}
//   - typedef dmem_rsp_t {logic [31:0] rdata; mem_err_t err;}
// - One sub-module, dmem_rsp_fifo:
//   - parametrised by DEPTH and payload type
//   - push/pop/count with FWFT head; asynchronous active-low reset
// - Top level holds lane arrays, decode/alignment check, extension logic, optional pipe register, credit counter.
// TESTING
// - Store W 0xDEADBEEF @0x10, load W @0x10 -> rdata 0xDEADBEEF, err OK, valid 2+OUT_REG cycles after accept.
// - Store B 0x80 @0x13, then load B signed @0x13 -> 0xFFFFFF80; load B unsigned -> 0x00000080.
// - Load H @0x11 -> err MISALIGNED, rdata 0; load W @0x10 unchanged afterwards (no side effect).
// - Hold i_rsp_ready=0 and issue back-to-back loads -> exactly RSP_DEPTH accepted, then o_req_ready=0;
//   release -> responses drain in issue order.
// - Assert i_reset_n=0 with 2 responses queued -> o_rsp_valid=0, o_req_ready=1; earlier stored data still readable.
// - With DMEM_BOUNDS_CHECK_EN: load W @0x0001_0000 (DEPTH_WORDS=1024) -> err OUT_OF_RANGE; without it -> data of word 0.

Source files
------------

// File: rtl/argon_mem_pkg.sv
// Shared types for the data memory controller.
//   mem_size_t  : access size code carried on i_req_size
//   mem_err_t   : response error code carried on o_rsp_err
//   dmem_rsp_t  : response payload stored in the response FIFO
//   load_extend : selects the B/H/W field of a read word and sign/zero-extends it
package argon_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_BAD = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        ERR_OK           = 2'd0,
        ERR_MISALIGNED   = 2'd1,
        ERR_BAD_SIZE     = 2'd2,
        ERR_OUT_OF_RANGE = 2'd3
    } mem_err_t;

    typedef struct packed {
        logic [31:0] rdata;
        mem_err_t    err;
    } dmem_rsp_t;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input mem_size_t   size,
                                                input logic [1:0]  off,
                                                input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    res = {{24{sgn & b[7]}}, b};
            SZ_H:    res = {{16{sgn & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// In-order response FIFO, first-word-fall-through from registered storage.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_push, i_data   : write one entry (caller never pushes when full)
//   i_pop            : remove the head when o_valid
//   o_valid, o_data  : head entry present / head payload (zero when empty)
//   o_count          : number of stored entries
module dmem_rsp_fifo
    import argon_mem_pkg::*;
#(
    parameter int  DEPTH = 3,
    parameter type T     = dmem_rsp_t
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop,
    output logic                       o_valid,
    output T                           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_valid = (count_q != '0);
    assign do_pop  = i_pop && o_valid;
    assign o_data  = o_valid ? mem_q[rd_ptr_q] : '0;
    assign o_count = count_q;

    always_comb begin
        wr_ptr_d = i_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({i_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is not reset; o_data is masked by o_valid instead.
    always_ff @(posedge i_clk) begin
        if (i_push) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-lane data memory behind valid/ready request and response channels.
// Every accepted request returns exactly one in-order response.
// Parameters: DEPTH_WORDS (power of two), OUT_REG (0|1 extra read pipe stage).
// Ports:
//   i_clk, i_reset_n        : clock, asynchronous active-low reset
//   i_req_valid/o_req_ready : request handshake
//   i_req_addr/we/size/signed/wdata : request fields
//   o_rsp_valid/i_rsp_ready : response handshake
//   o_rsp_rdata, o_rsp_err  : response payload
// Build option: define DMEM_BOUNDS_CHECK_EN to flag addresses with nonzero bits
// above the word-index field as OUT_OF_RANGE (otherwise they alias).
module data_mem_ctrl
    import argon_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int OUT_REG     = 0
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_signed,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic [1:0]  o_rsp_err
);

    localparam int RSP_DEPTH = 3 + OUT_REG;
    localparam int IDX_W     = $clog2(DEPTH_WORDS);
    localparam int CRD_W     = $clog2(RSP_DEPTH + 1);

    logic             accept, pop;
    mem_size_t        req_size;
    logic [IDX_W-1:0] req_idx;
    logic [31:0]      addr_hi;
    logic             addr_oor;
    mem_err_t         req_err;
    logic [3:0]       req_be;
    logic [31:0]      req_wdata_rep;
    logic             wr_en, rd_en;

    assign req_size = mem_size_t'(i_req_size);
    assign req_idx  = i_req_addr[2 +: IDX_W];
    assign addr_hi  = i_req_addr >> (2 + IDX_W);

`ifdef DMEM_BOUNDS_CHECK_EN
    assign addr_oor = (addr_hi != '0);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = |addr_hi;
    assign addr_oor       = 1'b0;
`endif

    always_comb begin
        req_err = ERR_OK;
        if ((req_size == SZ_H && i_req_addr[0]) ||
            (req_size == SZ_W && i_req_addr[1:0] != 2'b00))
            req_err = ERR_MISALIGNED;
        else if (req_size == SZ_BAD)
            req_err = ERR_BAD_SIZE;
        else if (addr_oor)
            req_err = ERR_OUT_OF_RANGE;
    end

    // Store data is replicated across lanes so each lane just takes its own byte.
    always_comb begin
        case (req_size)
            SZ_B: begin
                req_be        = 4'b0001 << i_req_addr[1:0];
                req_wdata_rep = {4{i_req_wdata[7:0]}};
            end
            SZ_H: begin
                req_be        = i_req_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata_rep = {2{i_req_wdata[15:0]}};
            end
            default: begin
                req_be        = 4'b1111;
                req_wdata_rep = i_req_wdata;
            end
        endcase
    end

    assign accept = i_req_valid && o_req_ready;
    assign wr_en  = accept && i_req_we && (req_err == ERR_OK);
    assign rd_en  = accept && !i_req_we;

    logic [31:0] rd_word;

    for (genvar n = 0; n < 4; n++) begin : g_lane
        logic [7:0] lane_q [DEPTH_WORDS];
        logic [7:0] rd_byte_q;
        always_ff @(posedge i_clk) begin
            if (wr_en && req_be[n]) lane_q[req_idx] <= req_wdata_rep[8*n +: 8];
            if (rd_en)              rd_byte_q       <= lane_q[req_idx];
        end
    end

    assign rd_word = {g_lane[3].rd_byte_q, g_lane[2].rd_byte_q,
                      g_lane[1].rd_byte_q, g_lane[0].rd_byte_q};

    logic       s1_valid_q, s1_we_q, s1_signed_q;
    mem_err_t   s1_err_q;
    mem_size_t  s1_size_q;
    logic [1:0] s1_off_q;
    dmem_rsp_t  s1_rsp;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_we_q     <= 1'b0;
            s1_signed_q <= 1'b0;
            s1_err_q    <= ERR_OK;
            s1_size_q   <= SZ_B;
            s1_off_q    <= 2'b00;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_we_q     <= i_req_we;
                s1_signed_q <= i_req_signed;
                s1_err_q    <= req_err;
                s1_size_q   <= req_size;
                s1_off_q    <= i_req_addr[1:0];
            end
        end
    end

    always_comb begin
        s1_rsp.err   = s1_err_q;
        s1_rsp.rdata = '0;
        if (!s1_we_q && s1_err_q == ERR_OK)
            s1_rsp.rdata = load_extend(rd_word, s1_size_q, s1_off_q, s1_signed_q);
    end

    logic      push_valid;
    dmem_rsp_t push_rsp;

    if (OUT_REG != 0) begin : g_out_reg
        logic      s2_valid_q;
        dmem_rsp_t s2_rsp_q;
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                s2_valid_q <= 1'b0;
                s2_rsp_q   <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_rsp_q <= s1_rsp;
            end
        end
        assign push_valid = s2_valid_q;
        assign push_rsp   = s2_rsp_q;
    end else begin : g_no_out_reg
        assign push_valid = s1_valid_q;
        assign push_rsp   = s1_rsp;
    end

    dmem_rsp_t                      rsp_head;
    logic [$clog2(RSP_DEPTH+1)-1:0] rsp_count_unused;

    dmem_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .T     (dmem_rsp_t)
    ) u_rsp_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (push_valid),
        .i_data    (push_rsp),
        .i_pop     (i_rsp_ready),
        .o_valid   (o_rsp_valid),
        .o_data    (rsp_head),
        .o_count   (rsp_count_unused)
    );

    assign o_rsp_rdata = rsp_head.rdata;
    assign o_rsp_err   = rsp_head.err;
    assign pop         = o_rsp_valid && i_rsp_ready;

    // Free response slots counted down; a credit covers the pipe and the FIFO,
    // so the FIFO can never overflow.
    logic [CRD_W-1:0] credit_q, credit_d;

    always_comb begin
        credit_d = credit_q;
        case ({accept, pop})
            2'b10:   credit_d = credit_q - 1'b1;
            2'b01:   credit_d = credit_q + 1'b1;
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) credit_q <= CRD_W'(RSP_DEPTH);
        else            credit_q <= credit_d;
    end

    assign o_req_ready = (credit_q != '0);

endmodule
